// File: rtl/ifid_skid_reg.sv
// IF/ID boundary register with a 2-entry skid buffer; one-cycle latency from accept to out_valid.
// in_ready is a flop (low only when both entries are full); flush squashes everything to NOP.
module ifid_skid_reg #(
    parameter int                 INSTR_W   = 8,
    parameter int                 PC_W      = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   squash_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic in_fire, out_fire, discard;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = (state_q != EMPTY) & out_ready;
    // A main beat taken by decode this cycle is not lost, so it does not count.
    assign discard  = ((state_q != EMPTY) & ~out_fire) | (state_q == TWO) | in_fire;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        cnt_d        = cnt_q;
        if (flush) begin
            state_d      = EMPTY;
            main_instr_d = NOP_INSTR;
            main_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
            skid_pc_d    = '0;
            if (discard && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                    end else if (in_fire) begin
                        state_d      = TWO;
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                    end else if (out_fire) begin
                        state_d      = EMPTY;
                        main_instr_d = NOP_INSTR;
                        main_pc_d    = '0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d      = ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        skid_instr_d = NOP_INSTR;
                        skid_pc_d    = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= EMPTY;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_instr  = main_instr_q;
    assign out_pc     = main_pc_q;
    assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: directed scenarios plus random traffic against a queue-based model.
module tb_ifid_skid_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid, in_ready, flush, out_valid, out_ready;
    logic [7:0] in_instr, in_pc, out_instr, out_pc;
    logic [3:0] squash_cnt;

    logic        in_valid2, in_ready2, flush2, out_valid2, out_ready2;
    logic [31:0] in_instr2, in_pc2, out_instr2, out_pc2;
    logic [1:0]  squash_cnt2;

    ifid_skid_reg dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .squash_cnt(squash_cnt)
    );

    ifid_skid_reg #(.INSTR_W(32), .PC_W(32), .NOP_INSTR(32'h0000_0013), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_instr(in_instr2), .in_pc(in_pc2), .flush(flush2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_instr(out_instr2), .out_pc(out_pc2), .squash_cnt(squash_cnt2)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed { logic [7:0] instr; logic [7:0] pc; } beat_t;
    beat_t q[$];
    int    m_cnt;
    logic       exp_valid, exp_rdy;
    logic [7:0] exp_instr, exp_pc;
    logic [3:0] exp_cnt;

    function automatic void upd();
        exp_valid = (q.size() != 0);
        exp_rdy   = (q.size() < 2);
        exp_instr = 8'h00;
        exp_pc    = 8'h00;
        if (exp_valid) begin
            exp_instr = q[0].instr;
            exp_pc    = q[0].pc;
        end
        exp_cnt = 4'(m_cnt);
    endfunction

    // Drive one cycle of stimulus, advance the model across the edge, return at the next negedge.
    task automatic step(input logic iv, input logic [7:0] ii, input logic [7:0] ip,
                        input logic fl, input logic ordy);
        int   sz;
        logic infire, disc;
        in_valid = iv; in_instr = ii; in_pc = ip; flush = fl; out_ready = ordy;
        sz = q.size();
        infire = iv && (sz < 2);
        @(posedge clk);
        if (fl) begin
            disc = (sz > 0 && !ordy) || (sz == 2) || infire;
            q.delete();
            if (disc && m_cnt < 15) m_cnt++;
        end else begin
            if (sz > 0 && ordy) void'(q.pop_front());
            if (infire) q.push_back({ii, ip});
        end
        upd();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
        in_valid2 = 0; in_instr2 = 0; in_pc2 = 0; flush2 = 0; out_ready2 = 0;
        q.delete(); m_cnt = 0; upd();
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
        reset = 1'b1;
        step(1, 8'h11, 8'h04, 0, 0);
        step(1, 8'h22, 8'h05, 0, 0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL two_ready got=%b exp=0", in_ready); end
        checks++; if (out_instr !== 8'h11) begin failures++; $display("FAIL two_instr got=%h exp=11", out_instr); end
        @(posedge clk); #2 reset = 1'b0; #1;
        q.delete(); m_cnt = 0; upd();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 8'h00 || out_pc !== 8'h00) begin failures++; $display("FAIL arst_data got=%h/%h exp=00/00", out_instr, out_pc); end
        checks++; if (in_ready !== 1'b1 || squash_cnt !== 4'd0) begin failures++; $display("FAIL arst_rdy_cnt got=%b/%0d exp=1/0", in_ready, squash_cnt); end
        @(negedge clk); reset = 1'b1;
        checks++; if (out_instr2 !== 32'h13 || out_valid2 !== 1'b0) begin failures++; $display("FAIL rst2 got=%h/%b exp=13/0", out_instr2, out_valid2); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            step(1, 8'hA1 + 8'(k), 8'(k), 0, 1);
            checks++;
            if (out_valid !== 1'b1 || out_instr !== 8'hA1 + 8'(k) || out_pc !== 8'(k) || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d got=%b/%h/%h/%b exp=1/%h/%h/1", k, out_valid, out_instr, out_pc, in_ready, 8'hA1 + 8'(k), 8'(k));
            end
        end
        step(0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0 || out_instr !== 8'h00) begin failures++; $display("FAIL stream_idle got=%b/%h exp=0/00", out_valid, out_instr); end
    endtask

    task automatic test_backpressure();
        step(1, 8'hB1, 8'h10, 0, 0);
        step(1, 8'hB2, 8'h11, 0, 0);
        checks++; if (in_ready !== 1'b0 || out_instr !== 8'hB1) begin failures++; $display("FAIL bp_full got=%b/%h exp=0/b1", in_ready, out_instr); end
        step(1, 8'hB3, 8'h12, 0, 0);
        checks++; if (out_instr !== 8'hB1 || out_pc !== 8'h10) begin failures++; $display("FAIL bp_hold got=%h/%h exp=b1/10", out_instr, out_pc); end
        step(0, 0, 0, 0, 1);
        checks++; if (out_instr !== 8'hB2 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_second got=%h/%b exp=b2/1", out_instr, in_ready); end
        step(1, 8'hB3, 8'h12, 0, 1);
        checks++; if (out_instr !== 8'hB3 || out_pc !== 8'h12) begin failures++; $display("FAIL bp_third got=%h/%h exp=b3/12", out_instr, out_pc); end
        step(0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        step(1, 8'hD1, 8'h20, 0, 0);
        step(1, 8'hD2, 8'h21, 0, 0);
        step(1, 8'hD3, 8'h22, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 8'h00 || squash_cnt !== 4'd1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_two got=%b/%h/%0d/%b exp=0/00/1/1", out_valid, out_instr, squash_cnt, in_ready);
        end
        step(1, 8'hC4, 8'h30, 0, 0);
        step(1, 8'hC5, 8'h31, 1, 1);
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 8'h00 || squash_cnt !== 4'd2) begin
            failures++;
            $display("FAIL flush_one got=%b/%h/%0d exp=0/00/2", out_valid, out_pc, squash_cnt);
        end
        step(0, 0, 0, 1, 1);
        checks++; if (squash_cnt !== 4'd2) begin failures++; $display("FAIL flush_empty got=%0d exp=2", squash_cnt); end
        step(1, 8'hC6, 8'h32, 0, 0);
        step(0, 0, 0, 1, 1);
        checks++; if (squash_cnt !== 4'd2 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_taken got=%0d/%b exp=2/0", squash_cnt, out_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 99) < 7), ($urandom_range(0, 9) < 5));
            checks++; if (out_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, exp_valid); end
            checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
            checks++; if (out_instr !== exp_instr) begin failures++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, out_instr, exp_instr); end
            checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, out_pc, exp_pc); end
            checks++; if (squash_cnt !== exp_cnt) begin failures++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, squash_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_midop();
        step(1, 8'h5A, 8'h40, 1, 0);
        step(1, 8'h61, 8'h41, 0, 0);
        step(1, 8'h62, 8'h42, 0, 0);
        #2 reset = 1'b0; #1;
        q.delete(); m_cnt = 0; upd();
        checks++;
        if (out_valid !== 1'b0 || squash_cnt !== 4'd0 || in_ready !== 1'b1 || out_instr !== 8'h00) begin
            failures++;
            $display("FAIL midop_rst got=%b/%0d/%b/%h exp=0/0/1/00", out_valid, squash_cnt, in_ready, out_instr);
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 5; k++) begin
            in_valid2 = 1'b1; in_instr2 = 32'hDEAD_0000 + 32'(k); in_pc2 = 32'(k); flush2 = 1'b1;
            @(negedge clk);
            checks++;
            if (squash_cnt2 !== 2'((k > 3) ? 3 : k) || out_instr2 !== 32'h13) begin
                failures++;
                $display("FAIL sat_%0d got=%0d/%h exp=%0d/00000013", k, squash_cnt2, out_instr2, (k > 3) ? 3 : k);
            end
        end
        in_valid2 = 1'b1; flush2 = 1'b0; in_instr2 = 32'hCAFE_F00D; in_pc2 = 32'h1000;
        @(negedge clk);
        checks++; if (out_instr2 !== 32'hCAFE_F00D || out_valid2 !== 1'b1) begin failures++; $display("FAIL wide_beat got=%h/%b exp=cafef00d/1", out_instr2, out_valid2); end
        in_valid2 = 1'b0; out_ready2 = 1'b1;
        @(negedge clk);
        checks++;
        if (out_instr2 !== 32'h13 || out_valid2 !== 1'b0 || squash_cnt2 !== 2'd3) begin
            failures++;
            $display("FAIL wide_idle got=%h/%b/%0d exp=00000013/0/3", out_instr2, out_valid2, squash_cnt2);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_midop();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifid_skid_reg.md
Name: ifid_skid_reg

Overview:
Parametrised IF/ID pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer. It replaces the plain stall-less latch: it carries instruction and PC, and absorbs one beat when ID back-pressures. On a jump/branch it squashes in-flight beats to a defined NOP, never X. Sits between the fetch stage (instruction memory + PC) and the decode stage.

Parameters:
INSTR_W, 8, instruction width in bits
PC_W, 8, program-counter width in bits
NOP_INSTR, {INSTR_W{1'b0}}, encoding driven on out_instr whenever out_valid=0
CNT_W, 4, width of saturating squash counter

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  fetch presents a beat
in_ready  output  1  register can accept a beat (registered)
in_instr  input  INSTR_W  fetched instruction
in_pc  input  PC_W  PC of fetched instruction
flush  input  1  synchronous squash request (jump/branch taken)
out_valid  output  1  decode-side beat valid
out_ready  input  1  decode accepts beat
out_instr  output  INSTR_W  instruction to decode
out_pc  output  PC_W  PC to decode
squash_cnt  output  CNT_W  count of flush cycles that discarded ≥1 beat, saturating

Behaviour:
- Interface: reset reset, asynchronous, active-low; clock clk. All other inputs are sampled on the rising edge of clk.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main reg (drives out_*) and skid reg. State is encoded EMPTY / ONE / TWO.
- Reset (reset=0, async): state=EMPTY, out_valid=0, out_instr=NOP_INSTR, out_pc=0, skid cleared, in_ready=1, squash_cnt=0.
- in_ready = 1 in EMPTY and ONE, 0 in TWO. It is a flop output with no combinational path from out_ready.
- Transitions (flush=0):
  - EMPTY: in_fire → ONE, main<=in. Otherwise stay.
  - ONE: in_fire & out_fire → ONE, main<=in. in_fire & !out_fire → TWO, skid<=in. !in_fire & out_fire → EMPTY. Otherwise hold.
  - TWO: out_fire → ONE, main<=skid. Otherwise hold. No in_fire is possible in TWO.
- Latency: 1 cycle from in_fire in EMPTY (or in ONE with concurrent out_fire) to out_valid=1 with that beat.
- Ordering: strict FIFO. A beat that enters skid always leaves after the beat in main.
- Held data: while out_valid=1 & out_ready=0, out_instr and out_pc are stable.
- Going idle: whenever the state becomes EMPTY, out_instr<=NOP_INSTR and out_pc<=0.
- flush=1 has the highest priority:
  - Next state is EMPTY; main and skid are discarded; out_valid=0, out_instr=NOP_INSTR, out_pc=0; in_ready=1 next cycle.
  - An in_fire in the flush cycle is accepted (the producer sees the handshake) and dropped.
  - An out_fire in the flush cycle still completes; decode owns that beat.
- squash_cnt increments by 1 on a flush cycle if any beat is discarded. The main beat counts as discarded only if it is not out_fire in that cycle; skid-valid or an in_fire also count. Saturates at 2^CNT_W-1; no wrap.
- Back-to-back flush: each cycle is evaluated independently. A flush with nothing to discard leaves squash_cnt unchanged.
- Reset mid-operation: immediate return to reset values, regardless of state; no beat survives.
- The outputs never carry X or Z after the first reset assertion.

Test Plan:
- Reset with state TWO (main=0x11/pc 0x04, skid=0x22/pc 0x05) → next sample: out_valid=0, out_instr=0x00, out_pc=0, in_ready=1, squash_cnt=0.
- Streaming: out_ready=1, inputs 0xA1..0xA4 with pc 0x00..0x03 on consecutive cycles → out_instr 0xA1..0xA4 one cycle later each, no bubbles, in_ready stays 1.
- Back-pressure: accept 0xB1, 0xB2 with out_ready=0 → in_ready=0, out_instr holds 0xB1. Drive 0xB3 with in_valid=1 → not accepted. Raise out_ready → 0xB1, then 0xB2, then 0xB3 (after re-accept), FIFO order intact.
- Flush in TWO with concurrent in_fire blocked, out_ready=0 → next cycle out_valid=0, out_instr=NOP_INSTR, squash_cnt=1, in_ready=1.
- Flush in ONE with in_fire of 0xC5 and out_fire of main 0xC4 → 0xC4 is consumed, 0xC5 is dropped, state EMPTY, squash_cnt +1. Flush again with nothing valid → squash_cnt unchanged.
- Saturation, CNT_W=2: 5 discarding flushes → squash_cnt=3, remains 3. Repeat with INSTR_W=32, PC_W=32, NOP_INSTR=0x00000013 → idle out_instr=0x00000013.
